// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package display_pkg;

  localparam int unsigned Y_W     = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned ANODE_W = 4;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_e;

  localparam logic [ANODE_W-1:0] ANODE_S0  = 4'b1110;
  localparam logic [ANODE_W-1:0] ANODE_S1  = 4'b1101;
  localparam logic [ANODE_W-1:0] ANODE_S2  = 4'b1011;
  localparam logic [ANODE_W-1:0] ANODE_S3  = 4'b0111;
  localparam logic [ANODE_W-1:0] ANODE_OFF = 4'b1111;

  typedef struct packed {
    logic [Y_W-1:0]  y;
    logic [OP_W-1:0] op;
  } disp_t;

  function automatic slot_e slot_next(input slot_e s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      default: return S0;
    endcase
  endfunction

  function automatic logic [ANODE_W-1:0] slot_anode(input slot_e s);
    case (s)
      S0:      return ANODE_S0;
      S1:      return ANODE_S1;
      S2:      return ANODE_S2;
      default: return ANODE_S3;
    endcase
  endfunction

  // Slot order: op code, constant zero, low result nibble, high result nibble.
  function automatic logic [DIGIT_W-1:0] slot_digit(input slot_e s, input disp_t d);
    case (s)
      S0:      return d.op;
      S1:      return 4'h0;
      S2:      return d.y[3:0];
      default: return d.y[7:4];
    endcase
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running 0..DIV-1 counter; tick_c is high during the terminal count cycle.
module scan_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit scan controller with a one-deep pending buffer swapped only at frame wrap.
// Build option: DISPLAY_BLANK_EN blanks the constant-zero slot and a leading-zero high nibble.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] y_in,
  input  logic [3:0] op_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] anode,
  output logic [3:0] digit,
  output logic       frame_done
);

  logic tick_c;
  logic accept_c;

  slot_e                slot_q, slot_d;
  disp_t                disp_q, disp_d;
  disp_t                pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 in_ready_q, in_ready_d;
  logic [ANODE_W-1:0]   anode_q, anode_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 frame_done_q, frame_done_d;

  scan_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_c (tick_c)
  );

  assign accept_c = in_valid && in_ready_q;

  always_comb begin
    slot_d       = slot_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    frame_done_d = 1'b0;

    if (tick_c) begin
      slot_d = slot_next(slot_q);
      // Display contents only change on the S3->S0 wrap, never mid-frame.
      if (slot_q == S3) begin
        frame_done_d = 1'b1;
        if (pend_vld_q) begin
          disp_d     = pend_q;
          pend_vld_d = 1'b0;
        end
      end
    end

    // An accept coinciding with the wrap lands in pending; it waits a full frame.
    if (accept_c) begin
      pend_d     = '{y: y_in, op: op_in};
      pend_vld_d = 1'b1;
    end

    in_ready_d = !pend_vld_d;

    anode_d = slot_anode(slot_d);
    digit_d = slot_digit(slot_d, disp_d);
`ifdef DISPLAY_BLANK_EN
    if ((slot_d == S1) || ((slot_d == S3) && (disp_d.y[7:4] == 4'h0))) anode_d = ANODE_OFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= S0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      anode_q      <= ANODE_S0;
      digit_q      <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      in_ready_q   <= in_ready_d;
      anode_q      <= anode_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign anode      = anode_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a frame-level reference model (REFRESH_DIV=4).
module tb_display_scan_ctrl;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] y_in = 8'h00;
  logic [3:0] op_in = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] anode;
  logic [3:0] digit;
  logic       frame_done;

  display_scan_ctrl #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y_in       (y_in),
    .op_in      (op_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .anode      (anode),
    .digit      (digit),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] anode;
    logic [3:0] digit;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: edges since reset release, the shown value and a one-deep pending slot.
  int unsigned k = 0;
  logic [7:0]  m_y = 8'h00;
  logic [3:0]  m_op = 4'h0;
  logic        m_pend = 1'b0;
  logic [7:0]  p_y = 8'h00;
  logic [3:0]  p_op = 4'h0;

  function automatic exp_t model_out();
    exp_t e;
    int unsigned s;
    logic [3:0] code;
    s = (k / DIV) % 4;
    code = 4'b1111;
    code[s] = 1'b0;
    case (s)
      0:       e.digit = m_op;
      1:       e.digit = 4'h0;
      2:       e.digit = m_y[3:0];
      default: e.digit = m_y[7:4];
    endcase
    e.anode = code;
`ifdef DISPLAY_BLANK_EN
    if (s == 1 || (s == 3 && m_y[7:4] == 4'h0)) e.anode = 4'b1111;
`endif
    e.fd  = (k % FRAME == 0);
    e.rdy = !m_pend;
    return e;
  endfunction

  task automatic step(input logic v, input logic [7:0] y, input logic [3:0] op);
    logic rdy_before;
    in_valid = v;
    y_in     = y;
    op_in    = op;
    @(posedge clk);
    #1;
    rdy_before = (k == 0) ? 1'b0 : !m_pend;
    k++;
    if (k % FRAME == 0 && m_pend) begin
      m_y    = p_y;
      m_op   = p_op;
      m_pend = 1'b0;
    end
    if (v && rdy_before) begin
      p_y    = y;
      p_op   = op;
      m_pend = 1'b1;
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 4'($urandom));
  endtask

  // Advance until the edge count modulo a frame equals r (bounded to one frame).
  task automatic idle_until(input int unsigned r);
    for (int i = 0; i < int'(FRAME) && (k % FRAME) != r; i++) step(1'b0, 8'($urandom), 4'($urandom));
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (anode !== 4'b1110 || digit !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got anode=%b digit=%h fd=%b exp anode=1110 digit=0 fd=0",
               tag, anode, digit, frame_done);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    k      = 0;
    m_y    = 8'h00;
    m_op   = 4'h0;
    m_pend = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (anode !== e.anode || digit !== e.digit || frame_done !== e.fd || in_ready !== e.rdy) begin
        errors++;
        $display("FAIL scan k=%0d got anode=%b digit=%h fd=%b rdy=%b exp anode=%b digit=%h fd=%b rdy=%b",
                 k, anode, digit, frame_done, in_ready, e.anode, e.digit, e.fd, e.rdy);
      end
    end
  end

  initial begin
    #12;
    check_reset("reset_state");
    release_reset();

    // Idle scan: two frames of zeros.
    idle(2 * FRAME);

    // Load mid-S1, then a second request while pending that must be dropped.
    idle_until(4);
    step(1'b1, 8'hA5, 4'h3);
    step(1'b1, 8'h11, 4'hF);
    idle(2 * FRAME);

    // Accept exactly on the wrap edge: visible only after the following wrap.
    idle_until(FRAME - 1);
    step(1'b1, 8'h42, 4'h7);
    idle(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) step(1'b1, 8'($urandom), 4'($urandom));
      else                        step(1'b0, 8'($urandom), 4'($urandom));
    end

    // Load just after a wrap, reset during S2 while still pending.
    idle_until(0);
    step(1'b1, 8'hC3, 4'h9);
    idle_until(2 * DIV + 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("async_reset");
    @(negedge clk);
    check_reset("reset_hold");
    release_reset();
    idle(2 * FRAME);

    // Leading-zero high nibble.
    step(1'b1, 8'h07, 4'h2);
    idle(3 * FRAME);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
